instr_fetch_queue: RTL and testbench

Instruction-fetch responder between the program counter and the decode stage. It accepts the fetch address driven by the PC register, issues it to a fixed-latency instruction memory, and buffers returned words with their PCs in a small FIFO presented to decode over a valid/ready handshake. When the in-flight reads plus the buffered words reach capacity, it raises `stall_o` so the PC holds its value. `flush_i` discards all buffered and in-flight fetches when a branch redirects the PC.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_queue.sv | 117 +++++++++++
 tb/tb_instr_fetch_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, defaults and the buffered entry type for the instruction fetch queue.
package fetch_pkg;
  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_MEM_LAT = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush clear and a fall-through head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [PTR_W:0] count_o
);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   count_reg;
  fetch_entry_t     mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Clear wins over any push or pop in the same cycle.
  assign do_push = push_i & ~clear_i;
  assign do_pop  = pop_i & (count_reg != '0) & ~clear_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset so it can map onto plain memory.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_reg] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_reg];
  assign count_o = count_reg;

  a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_i)
    !(do_push && !do_pop && count_reg == (PTR_W+1)'(DEPTH)));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch responder: PC accept, fixed-latency in-flight tracking, credit stall and output FIFO.
// Optional same-cycle return bypass when FETCH_BYPASS_EN is defined.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int MEM_LAT = DEFAULT_MEM_LAT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              inst_valid_o,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = $clog2(DEPTH + MEM_LAT + 1);

  logic               acc;
  logic               stall;
  logic [MEM_LAT-1:0] stage_valid;
  logic [ADDR_W-1:0]  stage_pc [MEM_LAT];
  logic [SUM_W-1:0]   inflight;
  logic [PTR_W:0]     fifo_count;
  fetch_entry_t       fifo_head;
  fetch_entry_t       ret_entry;
  fetch_entry_t       out_entry;
  logic               last_valid;
  logic               fifo_push;
  logic               fifo_pop;
  logic               out_valid;

  assign acc        = rst_i & start_i & ~stall & ~flush_i;
  assign mem_req_o  = acc;
  assign mem_addr_o = rst_i ? pc_i : '0;

  // One stage per cycle of memory latency; a flush kills every in-flight request.
  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_stage
    logic              valid_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              valid_in;
    logic [ADDR_W-1:0] pc_in;

    if (gi == 0) begin : g_head
      assign valid_in = acc;
      assign pc_in    = pc_i;
    end else begin : g_tail
      assign valid_in = stage_valid[gi-1];
      assign pc_in    = stage_pc[gi-1];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        valid_reg <= 1'b0;
        pc_reg    <= '0;
      end else begin
        valid_reg <= valid_in & ~flush_i;
        pc_reg    <= pc_in;
      end
    end

    assign stage_valid[gi] = valid_reg;
    assign stage_pc[gi]    = pc_reg;
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + SUM_W'(stage_valid[i]);
  end

  // Credits come only from registers, so a pop frees space one cycle later.
  assign stall   = (SUM_W'(fifo_count) + inflight) >= SUM_W'(DEPTH);
  assign stall_o = stall;

  assign last_valid = stage_valid[MEM_LAT-1];
  assign ret_entry  = '{pc: stage_pc[MEM_LAT-1], inst: mem_data_i};
  assign fifo_pop   = (fifo_count != '0) & inst_ready_i;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = last_valid & ~flush_i & (fifo_count == '0);
  assign fifo_push = last_valid & ~(bypass & inst_ready_i);
  assign out_valid = (fifo_count != '0) | bypass;
  assign out_entry = bypass ? ret_entry : fifo_head;
`else
  assign fifo_push = last_valid;
  assign out_valid = (fifo_count != '0);
  assign out_entry = fifo_head;
`endif

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .push_i      (fifo_push),
    .push_data_i (ret_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  // Empty-slot contents are undefined, so outputs read zero whenever nothing is valid.
  assign inst_valid_o = out_valid;
  assign inst_o       = out_valid ? out_entry.inst : '0;
  assign inst_pc_o    = out_valid ? out_entry.pc   : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed phases push expected entries, a monitor pops on handshake.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  localparam int DEPTH   = 4;
  localparam int MEM_LAT = 2;
`ifdef FETCH_BYPASS_EN
  localparam int   LAT = MEM_LAT;
  localparam logic BYP = 1'b1;
`else
  localparam int   LAT = MEM_LAT + 1;
  localparam logic BYP = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] pc_i = '0;
  logic              flush_i = 1'b0;
  logic              stall_o;
  logic              mem_req_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              inst_valid_o;
  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_ready_i = 1'b0;

  instr_fetch_queue #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_i   (mem_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Fixed-latency memory: data = address + 0x100, MEM_LAT cycles after the request.
  logic [ADDR_W-1:0] mem_pipe [MEM_LAT];
  initial for (int i = 0; i < MEM_LAT; i++) mem_pipe[i] = '0;
  always @(posedge clk_i) begin
    mem_pipe[0] <= mem_addr_o;
    for (int i = 1; i < MEM_LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_data_i = mem_pipe[MEM_LAT-1] + 32'h100;

  fetch_entry_t exp_q [$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int issued = 0;
  int issue_limit = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] first_pc, input int n);
    for (int i = 0; i < n; i++) begin
      logic [ADDR_W-1:0] p;
      p = first_pc + ADDR_W'(4 * i);
      exp_q.push_back('{pc: p, inst: p + 32'h100});
    end
  endtask

  // Monitor: one check per handshake, always against the oldest expected entry.
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && inst_valid_o === 1'b1 && inst_ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_inst: got pc=%0h inst=%0h required no output", inst_pc_o, inst_o);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        $display("[TB] cycle %0d pop pc=%0h inst=%0h", cyc, inst_pc_o, inst_o);
        check("inst_pc", 64'(inst_pc_o), 64'(e.pc));
        check("inst_data", 64'(inst_o), 64'(e.inst));
      end
    end
  end

  // Ends the current cycle; the PC register advances only on an accepted fetch.
  task automatic tick();
    logic acc_seen;
    @(negedge clk_i);
    acc_seen = rst_i & start_i & ~stall_o & ~flush_i;
    @(posedge clk_i);
    #1;
    cyc++;
    if (acc_seen) begin
      issued++;
      pc_i = pc_i + 32'd4;
      if (issued >= issue_limit) start_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    start_i = 1'b1;
    flush_i = 1'b0;
    inst_ready_i = 1'b1;
    pc_i = 32'h1234;
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_mem_req", 64'(mem_req_o), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    check("rst_valid", 64'(inst_valid_o), 64'd0);
    check("rst_inst", 64'(inst_o), 64'd0);
    check("rst_inst_pc", 64'(inst_pc_o), 64'd0);
    start_i = 1'b0;
    inst_ready_i = 1'b0;
    pc_i = '0;
    issued = 0;
    cyc = 0;
    rst_i = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Phase 1: free-running fetch, decode always ready.
    do_reset();
    start_i = 1'b1;
    inst_ready_i = 1'b1;
    issue_limit = 8;
    push_exp(32'h0, 8);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("p1_valid", 64'(inst_valid_o), 64'(cyc >= LAT && cyc < LAT + 8));
      check("p1_stall", 64'(stall_o), 64'd0);
      if (cyc == LAT) begin
        check("p1_first_inst", 64'(inst_o), 64'h100);
        check("p1_first_pc", 64'(inst_pc_o), 64'h0);
      end
    end
    wait_drain(5);
    check("p1_issued", 64'(issued), 64'd8);

    // Phase 2: backpressure fills all credits, then release.
    do_reset();
    start_i = 1'b1;
    issue_limit = 8;
    push_exp(32'h0, 8);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("p2_stall", 64'(stall_o), 64'(cyc >= 4));
      if (cyc == MEM_LAT) check("p2_valid_early", 64'(inst_valid_o), 64'(BYP));
      if (cyc == 3) begin
        check("p2_valid_buf", 64'(inst_valid_o), 64'd1);
        check("p2_pc_buf", 64'(inst_pc_o), 64'h0);
      end
    end
    check("p2_issued_stalled", 64'(issued), 64'd4);
    inst_ready_i = 1'b1;
    wait_drain(40);
    check("p2_issued", 64'(issued), 64'd8);

    // Phase 3: flush with two buffered and two in flight, then redirect to 0x40.
    do_reset();
    start_i = 1'b1;
    issue_limit = 4;
    for (int k = 0; k < 4; k++) tick();
    check("p3_stall_full", 64'(stall_o), 64'd1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("p3_valid_after_flush", 64'(inst_valid_o), 64'd0);
    check("p3_stall_after_flush", 64'(stall_o), 64'd0);
    pc_i = 32'h40;
    issued = 0;
    issue_limit = 1;
    start_i = 1'b1;
    inst_ready_i = 1'b1;
    push_exp(32'h40, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("p3_valid", 64'(inst_valid_o), 64'(cyc == 5 + LAT));
      if (cyc == 5 + LAT) check("p3_redirect_pc", 64'(inst_pc_o), 64'h40);
    end
    wait_drain(2);

    // Phase 4: asynchronous reset in the middle of a stream.
    do_reset();
    start_i = 1'b1;
    inst_ready_i = 1'b1;
    issue_limit = 100;
    push_exp(32'h0, 16);
    for (int k = 0; k < 5; k++) tick();
    #2;
    rst_i = 1'b0;
    #1;
    check("p4_stall", 64'(stall_o), 64'd0);
    check("p4_mem_req", 64'(mem_req_o), 64'd0);
    check("p4_mem_addr", 64'(mem_addr_o), 64'd0);
    check("p4_valid", 64'(inst_valid_o), 64'd0);
    check("p4_inst", 64'(inst_o), 64'd0);
    check("p4_inst_pc", 64'(inst_pc_o), 64'd0);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    cyc = 0;
    rst_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("p4_no_stale", 64'(inst_valid_o), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
